// File: rtl/aes_stim_harness_if.sv
// Bus between the AES stimulus harness and its controller / core wrapper.
// The controller side (master) issues run requests and returns core results;
// the harness side (slave) drives the vectors, status and signature.
interface aes_stim_harness_if #(
    parameter int DATA_W = 128,
    parameter int KEY_W  = 128,
    parameter int SIG_W  = 16,
    parameter int CNT_W  = 16
);
    logic              start;
    logic [CNT_W-1:0]  run_len;
    logic [1:0]        state_mode;
    logic [1:0]        key_mode;
    logic [DATA_W-1:0] state_seed;
    logic [KEY_W-1:0]  key_seed;
    logic [DATA_W-1:0] core_state;
    logic [KEY_W-1:0]  core_key;
    logic [DATA_W-1:0] core_out;
    logic              busy;
    logic              done;
    logic [SIG_W-1:0]  sig;
    logic              out;

    modport master (
        output start, run_len, state_mode, key_mode, state_seed, key_seed, core_out,
        input  core_state, core_key, busy, done, sig, out
    );

    modport slave (
        input  start, run_len, state_mode, key_mode, state_seed, key_seed, core_out,
        output core_state, core_key, busy, done, sig, out
    );
endinterface

// File: rtl/aes_stim_harness.sv
// Stimulus-and-signature harness for a pipelined AES core.
// Generates state/key vectors (hold/inc/dec/Galois LFSR), tracks valid core
// outputs through a latency-matched tag pipe and folds them into a MISR.
module aes_stim_harness #(
    parameter int                DATA_W    = 128,
    parameter int                KEY_W     = 128,
    parameter int                SIG_W     = 16,
    parameter int                CNT_W     = 16,
    parameter int                CORE_LAT  = 21,
    parameter logic [127:0]      LFSR_POLY = 128'h87,
    parameter logic [SIG_W-1:0]  MISR_POLY = 16'h002D
) (
    input logic              clk,
    input logic              rst,
    aes_stim_harness_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} fsm_t;
    typedef enum logic [1:0] {MODE_HOLD, MODE_INC, MODE_DEC, MODE_LFSR} mode_t;

    localparam int DRAIN_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;
    localparam logic [DATA_W-1:0]  STATE_ONE = DATA_W'(1);
    localparam logic [KEY_W-1:0]   KEY_ONE   = KEY_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_LD  = DRAIN_W'(CORE_LAT - 1);

    fsm_t              fsm;
    mode_t             state_mode_q;
    mode_t             key_mode_q;
    logic [DATA_W-1:0] state_q;
    logic [KEY_W-1:0]  key_q;
    logic [CNT_W-1:0]  count;
    logic [DRAIN_W-1:0] drain_cnt;
    logic [CORE_LAT-1:0] tag_pipe;
    logic [SIG_W-1:0]  sig_q;
    logic              busy_q;
    logic              done_q;
    logic [SIG_W-1:0]  fold_w;
    logic [SIG_W-1:0]  misr_next;

    function automatic logic [DATA_W-1:0] next_state(input mode_t m, input logic [DATA_W-1:0] x);
        case (m)
            MODE_INC:  return x + STATE_ONE;
            MODE_DEC:  return x - STATE_ONE;
            MODE_LFSR: begin
                if (x == '0) return STATE_ONE;
                return (x << 1) ^ (x[DATA_W-1] ? LFSR_POLY[DATA_W-1:0] : '0);
            end
            default:   return x;
        endcase
    endfunction

    function automatic logic [KEY_W-1:0] next_key(input mode_t m, input logic [KEY_W-1:0] x);
        case (m)
            MODE_INC:  return x + KEY_ONE;
            MODE_DEC:  return x - KEY_ONE;
            MODE_LFSR: begin
                if (x == '0) return KEY_ONE;
                return (x << 1) ^ (x[KEY_W-1] ? LFSR_POLY[KEY_W-1:0] : '0);
            end
            default:   return x;
        endcase
    endfunction

    // Fold the core result into SIG_W bits and form the next MISR value.
    always_comb begin
        fold_w = '0;
        for (int unsigned i = 0; i < DATA_W / SIG_W; i++) begin
            fold_w = fold_w ^ bus.core_out[i*SIG_W +: SIG_W];
        end
        misr_next = {sig_q[SIG_W-2:0], 1'b0} ^ (sig_q[SIG_W-1] ? MISR_POLY : '0) ^ fold_w;
    end

    // Control FSM, vector generators, tag pipe and signature register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm          <= IDLE;
            state_mode_q <= MODE_HOLD;
            key_mode_q   <= MODE_HOLD;
            state_q      <= '0;
            key_q        <= '0;
            count        <= '0;
            drain_cnt    <= '0;
            tag_pipe     <= '0;
            sig_q        <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            // Tags shift every cycle; only RUN injects a valid tag, so the
            // pipe self-flushes during DRAIN. The start branch below overrides.
            tag_pipe <= (tag_pipe << 1) | CORE_LAT'(fsm == RUN);
            if (tag_pipe[CORE_LAT-1]) begin
                sig_q <= misr_next;
            end
            done_q <= 1'b0;

            case (fsm)
                IDLE: begin
                    if (bus.start) begin
                        state_mode_q <= mode_t'(bus.state_mode);
                        key_mode_q   <= mode_t'(bus.key_mode);
                        state_q      <= bus.state_seed;
                        key_q        <= bus.key_seed;
                        sig_q        <= '0;
                        tag_pipe     <= '0;
                        count        <= bus.run_len;
                        if (bus.run_len != '0) begin
                            fsm    <= RUN;
                            busy_q <= 1'b1;
                        end else begin
                            fsm    <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    state_q <= next_state(state_mode_q, state_q);
                    key_q   <= next_key(key_mode_q, key_q);
                    count   <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        fsm       <= DRAIN;
                        drain_cnt <= DRAIN_LD;
                    end
                end
                DRAIN: begin
                    if (drain_cnt == '0) begin
                        fsm    <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_W'(1);
                    end
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    assign bus.core_state = state_q;
    assign bus.core_key   = key_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.sig        = sig_q;
    assign bus.out        = ^bus.core_out;

endmodule

// File: tb/tb_aes_stim_harness.sv
// Scoreboard bench for aes_stim_harness: the driver pushes cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_aes_stim_harness;

    localparam int DW  = 128;
    localparam int KW  = 128;
    localparam int SW  = 16;
    localparam int CW  = 16;
    localparam int LAT = 21;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    aes_stim_harness_if #(.DATA_W(DW), .KEY_W(KW), .SIG_W(SW), .CNT_W(CW)) bus ();

    aes_stim_harness #(
        .DATA_W(DW), .KEY_W(KW), .SIG_W(SW), .CNT_W(CW), .CORE_LAT(LAT),
        .LFSR_POLY(128'h87), .MISR_POLY(16'h002D)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    // Identity core with CORE_LAT cycles of delay.
    logic [DW-1:0] dly [LAT];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) dly[i] <= '0;
        end else begin
            dly[0] <= bus.core_state;
            for (int i = 1; i < LAT; i++) dly[i] <= dly[i-1];
        end
    end
    assign bus.core_out = dly[LAT-1];

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed { int c; int kind; logic [127:0] val; } item_t;
    typedef struct packed { int c; logic [15:0] sig; } done_t;
    item_t       exp_q[$];
    done_t       done_q[$];
    logic [127:0] ev_state[$];
    logic [127:0] ev_key[$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [127:0] v);
        logic [15:0] f = '0;
        for (int i = 0; i < 8; i++) f = f ^ v[i*16 +: 16];
        return {s[14:0], 1'b0} ^ (s[15] ? 16'h002D : 16'h0000) ^ f;
    endfunction

    // Monitor: compare everything due this cycle, and every done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            check("parity", {127'd0, bus.out}, {127'd0, ^bus.core_out});
            while (exp_q.size() > 0 && exp_q[0].c <= cyc) begin
                item_t it;
                it = exp_q.pop_front();
                if (it.c < cyc) check("stale_item", 128'(it.c), 128'(cyc));
                case (it.kind)
                    0: check("core_state", bus.core_state, it.val);
                    1: check("core_key", bus.core_key, it.val);
                    2: check("sig_held", {112'd0, bus.sig}, it.val);
                    default: check("busy", {127'd0, bus.busy}, it.val);
                endcase
            end
            if (bus.done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 128'd1, 128'd0);
                end else begin
                    done_t d;
                    d = done_q.pop_front();
                    check("done_cycle", 128'(cyc), 128'(d.c));
                    check("done_sig", {112'd0, bus.sig}, {112'd0, d.sig});
                end
            end
        end
    end

    // One run: pushes expectations from ev_state/ev_key, then plays it out.
    // ign_at: cycle (relative to start) of an extra start pulse; rst_at: reset cycle.
    task automatic run_vec(input int n, input logic [1:0] sm, input logic [1:0] km,
                           input logic [127:0] ss, input logic [127:0] ks,
                           input bit use_hand, input logic [15:0] hand_sig,
                           input int ign_at, input int rst_at);
        int s, dc, nv;
        logic [15:0] sg;
        @(negedge clk);
        s = cyc;
        bus.start      = 1'b1;
        bus.run_len    = CW'(n);
        bus.state_mode = sm;
        bus.key_mode   = km;
        bus.state_seed = ss;
        bus.key_seed   = ks;
        nv = (rst_at > 0) ? rst_at - 1 : n;
        sg = '0;
        for (int j = 0; j < nv; j++) begin
            if (j == 0) exp_q.push_back('{s + 1, 3, 128'd1});
            exp_q.push_back('{s + 1 + j, 0, ev_state[j]});
            exp_q.push_back('{s + 1 + j, 1, ev_key[j]});
            sg = misr_step(sg, ev_state[j]);
        end
        if (use_hand) sg = hand_sig;
        dc = (n == 0) ? s + 1 : s + n + LAT + 1;
        if (rst_at == 0) begin
            if (n > 0) exp_q.push_back('{dc - 1, 3, 128'd1});
            exp_q.push_back('{dc, 3, 128'd0});
            exp_q.push_back('{dc + 3, 2, {112'd0, sg}});
            done_q.push_back('{dc, sg});
        end
        for (int k = 1; k <= n + LAT + 6; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (k == ign_at) begin
                bus.start      = 1'b1;
                bus.run_len    = CW'(3);
                bus.state_seed = 128'hDEAD;
                bus.key_seed   = 128'hBEEF;
            end
            if (k == ign_at + 1) bus.start = 1'b0;
            if (k == rst_at) begin
                rst = 1'b1;
                #1;
                check("rst_busy", {127'd0, bus.busy}, 128'd0);
                check("rst_done", {127'd0, bus.done}, 128'd0);
                check("rst_sig", {112'd0, bus.sig}, 128'd0);
                check("rst_state", bus.core_state, 128'd0);
                check("rst_key", bus.core_key, 128'd0);
            end
            if (rst_at > 0 && k == rst_at + 2) rst = 1'b0;
        end
        ev_state.delete();
        ev_key.delete();
    endtask

    initial begin
        logic [127:0] ones;
        ones = '1;
        bus.start = 1'b0; bus.run_len = '0; bus.state_mode = '0; bus.key_mode = '0;
        bus.state_seed = '0; bus.key_seed = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", {127'd0, bus.busy}, 128'd0);
        check("reset_done", {127'd0, bus.done}, 128'd0);
        check("reset_sig", {112'd0, bus.sig}, 128'd0);
        check("reset_state", bus.core_state, 128'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // state inc, key hold, seeds 0: signature worked by hand is 16'h0003
        for (int j = 0; j < 4; j++) begin ev_state.push_back(128'(j)); ev_key.push_back('0); end
        run_vec(4, 2'b01, 2'b00, '0, '0, 1'b1, 16'h0003, 0, 0);

        // state LFSR from 0 escapes lock-up
        ev_state = '{128'd0, 128'd1, 128'd2, 128'd4};
        ev_key   = '{128'd0, 128'd0, 128'd0, 128'd0};
        run_vec(4, 2'b11, 2'b00, '0, '0, 1'b0, '0, 0, 0);

        // state LFSR feedback from top bit
        ev_state = '{128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h87};
        ev_key   = '{128'h55, 128'h55};
        run_vec(2, 2'b11, 2'b00, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h55, 1'b0, '0, 0, 0);

        // state dec wraps below 0
        ev_state = '{128'd0, ones};
        ev_key   = '{128'd0, 128'd0};
        run_vec(2, 2'b10, 2'b00, '0, '0, 1'b0, '0, 0, 0);

        // key inc wraps from all-ones
        ev_state = '{128'h1234, 128'h1234};
        ev_key   = '{ones, 128'd0};
        run_vec(2, 2'b00, 2'b01, 128'h1234, ones, 1'b0, '0, 0, 0);

        // zero-length run
        run_vec(0, 2'b01, 2'b01, 128'h77, 128'h77, 1'b1, 16'h0000, 0, 0);

        // 10-vector run with a stray start in cycle 5
        for (int j = 0; j < 10; j++) begin
            ev_state.push_back(128'(100 + j));
            ev_key.push_back(128'd7 - 128'(j));
        end
        run_vec(10, 2'b01, 2'b10, 128'd100, 128'd7, 1'b0, '0, 5, 0);

        // reset in RUN cycle 3 aborts the run
        ev_state = '{128'd5, 128'd6};
        ev_key   = '{128'd9, 128'd10};
        run_vec(8, 2'b01, 2'b01, 128'd5, 128'd9, 1'b0, '0, 0, 3);

        // normal operation after the reset
        for (int j = 0; j < 4; j++) begin ev_state.push_back(128'(j)); ev_key.push_back('0); end
        run_vec(4, 2'b01, 2'b00, '0, '0, 1'b1, 16'h0003, 0, 0);

        repeat (4) @(negedge clk);
        check("pending_items", 128'(exp_q.size()), 128'd0);
        check("pending_done", 128'(done_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_stim_harness.md
Name: aes_stim_harness

Overview:
- Parametrised stimulus-and-signature harness for a pipelined AES core.
- Generates state and key vectors with a selectable mode per register: hold, increment, decrement or Galois LFSR.
- Tracks which core outputs are valid through a latency-matched tag pipe and compresses valid outputs into a SIG_W-bit MISR signature.
- Keeps the legacy single-bit parity output; the AES core is instantiated outside the harness.

Parameters:
- DATA_W, 128, state/core-output width; must be a multiple of SIG_W.
- KEY_W, 128, key width.
- SIG_W, 16, MISR signature width.
- CNT_W, 16, run-length counter width.
- CORE_LAT, 21, core latency in cycles from vector presented to output sampled; must be ≥1.
- LFSR_POLY, 128'h87, Galois feedback taps; the low DATA_W/KEY_W bits are used for state/key respectively.
- MISR_POLY, 16'h002D, MISR feedback taps, SIG_W bits.

Ports:
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- start, in, 1: single-cycle run request; sampled only in IDLE.
- run_len, in, CNT_W: number of vectors in the run; sampled with start.
- state_mode, in, 2: 00 hold, 01 inc, 10 dec, 11 LFSR; sampled with start.
- key_mode, in, 2: same encoding as state_mode; sampled with start.
- state_seed, in, DATA_W: initial state value; loaded at start.
- key_seed, in, KEY_W: initial key value; loaded at start.
- core_state, out, DATA_W: registered state vector driven to the core.
- core_key, out, KEY_W: registered key vector driven to the core.
- core_out, in, DATA_W: core result.
- busy, out, 1: high in RUN and DRAIN.
- done, out, 1: one-cycle pulse in DONE.
- sig, out, SIG_W: MISR value; held after done until the next start.
- out, out, 1: ^core_out, combinational (legacy parity).

Behaviour:
- Reset (asynchronous): FSM=IDLE; core_state, core_key, sig, counters and tag pipe all 0; busy=0; done=0.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - When start=1, latch the modes, load the seeds into core_state/core_key, clear sig and the tag pipe, and load count=run_len.
  - Go to RUN if run_len≠0, else to DONE.
- RUN: one vector per cycle.
  - The current core_state/core_key form the vector; a tag of 1 enters the tag pipe.
  - On the same edge each register advances per its mode:
    - hold: unchanged.
    - inc: +1 mod 2^W.
    - dec: −1 mod 2^W.
    - LFSR: next = (x<<1) ^ (x[W-1] ? POLY : 0); if x==0, next = 1 (lock-up escape).
  - count decrements; after the run_len-th vector go to DRAIN.
- DRAIN: hold core_state/core_key; shift 0 tags for exactly CORE_LAT cycles, then go to DONE.
- DONE: done=1 for one cycle; return to IDLE.
- Tag pipe: CORE_LAT deep. When its tail tag=1, core_out sampled on that edge is the result of the vector presented CORE_LAT cycles earlier.
- MISR: when the tail tag=1, sig <= {sig[SIG_W-2:0],1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : 0) ^ fold(core_out). fold = XOR of the DATA_W/SIG_W SIG_W-bit slices.
- Timing: start sampled on edge 0; RUN occupies cycles 1..N; DRAIN occupies N+1..N+CORE_LAT; done is high in cycle N+CORE_LAT+1. For run_len=0, done is high in cycle 1.
- start outside IDLE is ignored; no queuing.
- Reset mid-run aborts immediately to the reset values; no done pulse.
- All arithmetic wraps modulo 2^W with no carry out.

Test Plan:
- Reset: assert rst in RUN cycle 3 -> same edge busy=0, sig=0, core_state=0, no done; after deassert, start works normally.
- Core modelled as identity delay of CORE_LAT: state inc, key hold, seeds 0, run_len=4 -> core_state 0,1,2,3 in cycles 1..4; core_key=0 throughout; done in cycle 26; sig=16'h0003.
- State LFSR mode:
  - seed 0 -> vectors 0,1,2,4.
  - seed 128'h8000…0 -> vectors 128'h8000…0, 128'h87.
- State dec, seed 0, run_len=2 -> vectors 0, 128'hFFFF…F.
- Key inc, seed all-ones, run_len=2 -> keys all-ones, then 0 (wrap).
- run_len=0 -> done in cycle 1, busy never high, sig=0; start pulsed in cycle 5 of a 10-vector run -> ignored, exactly 10 vectors and one done.
